fetch_ibuf: RTL and testbench

- Parametrised superscalar fetch stage with an internal circular instruction buffer.
- Issues a base PC to the icache. Accepts up to FETCH_WIDTH in-order instructions per cycle, stopping at the first missing slot. Presents up to DISPATCH_WIDTH oldest instructions, with their PCs, to dispatch.
- Sits between icache and dispatch. Handles ROB-head branch redirects by flushing. Stops fetching after a WFI until redirected.

---
 rtl/fetch_ibuf_pkg.sv | 21 ++
 rtl/ibuf_fifo.sv | 95 +++++++++
 rtl/fetch_ibuf.sv | 155 +++++++++++++++
 tb/tb_fetch_ibuf.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ibuf_pkg.sv
// Shared fetch-stage definitions: WFI encoding, fetch FSM states and the
// buffered instruction record.
package sys_defs;

  localparam logic [31:0] INST_WFI = 32'h1050_0073;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ibuf_entry_t;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Multi-push / multi-pop circular buffer with a head-window read port.
// The caller guarantees push_cnt_i fits the free space and pop_cnt_i does
// not exceed count_o; flush_i empties the buffer and overrides push/pop.
module ibuf_fifo
  import sys_defs::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PUSH_W = 3,
  parameter int unsigned POP_W  = 3,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned PSHW  = $clog2(PUSH_W + 1),
  localparam int unsigned POPW  = $clog2(POP_W + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic [PSHW-1:0]          push_cnt_i,
  input  ibuf_entry_t [PUSH_W-1:0] push_data_i,
  input  logic [POPW-1:0]          pop_cnt_i,
  output logic [CW-1:0]            count_o,
  output ibuf_entry_t [POP_W-1:0]  rd_data_o
);

  ibuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr [PUSH_W];
  logic [PW-1:0] rd_ptr [POP_W];

  // Slot addresses; pointer width makes the modulo-DEPTH wrap implicit.
  always_comb begin
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      wr_ptr[i] = tail_q + PW'(i);
    end
    for (int unsigned i = 0; i < POP_W; i++) begin
      rd_ptr[i] = head_q + PW'(i);
    end
  end

  // Next pointer/occupancy values from this cycle's push and pop counts.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      tail_d  = tail_q + PW'(push_cnt_i);
      head_d  = head_q + PW'(pop_cnt_i);
      count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so the read window shows zeros.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < PUSH_W; i++) begin
        if (!flush_i && (PSHW'(i) < push_cnt_i)) begin
          mem_q[wr_ptr[i]] <= push_data_i[i];
        end
      end
    end
  end

  // Head window: entries head+i, regardless of occupancy.
  always_comb begin
    for (int unsigned i = 0; i < POP_W; i++) begin
      rd_data_o[i] = mem_q[rd_ptr[i]];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_ibuf.sv
// Superscalar fetch stage: drives the icache base PC, enqueues the in-order
// hit prefix into a circular buffer, presents the oldest entries to dispatch,
// halts after a WFI and flushes on ROB-head redirects.
module fetch_ibuf
  import sys_defs::*;
#(
  parameter int unsigned FETCH_WIDTH    = 3,
  parameter int unsigned DISPATCH_WIDTH = 3,
  parameter int unsigned IBUF_DEPTH     = 8,
  parameter logic [31:0] RESET_PC       = 32'h0,
  localparam int unsigned KW            = $clog2(FETCH_WIDTH + 1),
  localparam int unsigned TW            = $clog2(DISPATCH_WIDTH + 1),
  localparam int unsigned CW            = $clog2(IBUF_DEPTH + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 redirect_valid,
  input  logic [31:0]                          redirect_pc,
  input  logic [FETCH_WIDTH-1:0][31:0]         icache_inst,
  input  logic [FETCH_WIDTH-1:0]               icache_hit,
  input  logic [TW-1:0]                        dispatch_take,
  output logic [31:0]                          fetch_pc,
  output logic [DISPATCH_WIDTH-1:0][31:0]      out_inst,
  output logic [DISPATCH_WIDTH-1:0][31:0]      out_pc,
  output logic [DISPATCH_WIDTH-1:0]            out_valid,
  output logic [CW-1:0]                        ibuf_count,
  output logic                                 fetch_stall
);

  fetch_state_t                     state_q, state_d;
  logic [31:0]                      pc_q, pc_d;
  logic [KW-1:0]                    push_cnt;
  logic [TW-1:0]                    pop_cnt;
  logic [CW-1:0]                    count;
  logic                             wfi_enq;
  ibuf_entry_t [FETCH_WIDTH-1:0]    push_data;
  ibuf_entry_t [DISPATCH_WIDTH-1:0] rd_data;
  int unsigned                      hit_len;
  int unsigned                      room;
  int unsigned                      k_lim;
  int unsigned                      k_enq;
  int unsigned                      d_deq;
  logic                             hit_run;

  // Enqueue count: hit prefix, limited by start-of-cycle free space, cut
  // after the first WFI. Free space ignores same-cycle dequeue on purpose
  // so dispatch_take has no combinational path toward the icache side.
  always_comb begin
    hit_len = 0;
    hit_run = 1'b1;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (hit_run && icache_hit[i]) begin
        hit_len = hit_len + 1;
      end else begin
        hit_run = 1'b0;
      end
    end
    room    = IBUF_DEPTH - 32'(count);
    k_lim   = umin(hit_len, room);
    k_enq   = k_lim;
    wfi_enq = 1'b0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (i < k_lim && !wfi_enq && icache_inst[i] == INST_WFI) begin
        k_enq   = i + 1;
        wfi_enq = 1'b1;
      end
    end
    if (redirect_valid || state_q != FETCH_RUN) begin
      k_enq   = 0;
      wfi_enq = 1'b0;
    end
    push_cnt = KW'(k_enq);
  end

  // Dequeue count, clamped to occupancy; a redirect suppresses it.
  always_comb begin
    d_deq = umin(32'(dispatch_take), 32'(count));
    if (redirect_valid) begin
      d_deq = 0;
    end
    pop_cnt = TW'(d_deq);
  end

  // Entries to write: slot j carries PC pc+4*j.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      push_data[i].inst = icache_inst[i];
      push_data[i].pc   = pc_q + 32'(4 * i);
    end
  end

  // Fetch FSM / PC next state; redirect wins over everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = FETCH_RUN;
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          pc_d = pc_q + (32'(push_cnt) << 2);
          if (wfi_enq) begin
            state_d = FETCH_HALTED;
          end
        end
        FETCH_HALTED: begin
          pc_d = pc_q;
        end
        default: begin
          state_d = FETCH_RUN;
        end
      endcase
    end
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ibuf_fifo #(
    .DEPTH  (IBUF_DEPTH),
    .PUSH_W (FETCH_WIDTH),
    .POP_W  (DISPATCH_WIDTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_cnt_i   (pop_cnt),
    .count_o     (count),
    .rd_data_o   (rd_data)
  );

  // Dispatch window and status outputs.
  always_comb begin
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      out_inst[i]  = rd_data[i].inst;
      out_pc[i]    = rd_data[i].pc;
      out_valid[i] = (i < 32'(count)) && !redirect_valid;
    end
    fetch_pc    = pc_q;
    ibuf_count  = count;
    fetch_stall = (state_q == FETCH_RUN) && (push_cnt == '0);
  end

endmodule

// File: tb/tb_fetch_ibuf.sv
// Directed bench for fetch_ibuf with hand-computed expectations.
module tb_fetch_ibuf;

  localparam int unsigned FW = 3;
  localparam int unsigned DW = 3;
  localparam logic [31:0] WFI = 32'h1050_0073;
  localparam logic [31:0] OFS = 32'h0100_0000;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [FW-1:0][31:0]  icache_inst;
  logic [FW-1:0]        icache_hit;
  logic [1:0]           dispatch_take;
  logic [31:0]          fetch_pc;
  logic [DW-1:0][31:0]  out_inst;
  logic [DW-1:0][31:0]  out_pc;
  logic [DW-1:0]        out_valid;
  logic [3:0]           ibuf_count;
  logic                 fetch_stall;

  int errors = 0;
  int checks = 0;

  fetch_ibuf #(
    .FETCH_WIDTH    (3),
    .DISPATCH_WIDTH (3),
    .IBUF_DEPTH     (8),
    .RESET_PC       (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_inst    (icache_inst),
    .icache_hit     (icache_hit),
    .dispatch_take  (dispatch_take),
    .fetch_pc       (fetch_pc),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_valid      (out_valid),
    .ibuf_count     (ibuf_count),
    .fetch_stall    (fetch_stall)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_slots(input logic [31:0] base);
    for (int i = 0; i < FW; i++) icache_inst[i] = base + 32'(4 * i) + OFS;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    icache_hit = '1; dispatch_take = '0; drive_slots(32'h0);
    #2;
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc got=%h exp=%h", fetch_pc, 32'h0); end
    checks++; if (ibuf_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ibuf_count); end
    checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL reset_out_valid got=%b exp=000", out_valid); end
    checks++; if (out_inst !== '0) begin errors++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", fetch_stall); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] prev;
    dispatch_take = 2'd3; icache_hit = '1;
    for (int n = 0; n < 4; n++) begin
      drive_slots(32'(12 * n));
      #1;
      prev = 32'(12 * (n - 1));
      checks++; if (fetch_pc !== 32'(12 * n)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", n, fetch_pc, 32'(12 * n)); end
      checks++; if (ibuf_count !== ((n == 0) ? 4'd0 : 4'd3)) begin errors++; $display("FAIL stream_count[%0d] got=%0d", n, ibuf_count); end
      checks++; if (out_valid !== ((n == 0) ? 3'b000 : 3'b111)) begin errors++; $display("FAIL stream_valid[%0d] got=%b", n, out_valid); end
      if (n > 0) begin
        checks++; if (out_pc[0] !== prev) begin errors++; $display("FAIL stream_out_pc0[%0d] got=%h exp=%h", n, out_pc[0], prev); end
        checks++; if (out_pc[2] !== prev + 32'd8) begin errors++; $display("FAIL stream_out_pc2[%0d] got=%h exp=%h", n, out_pc[2], prev + 32'd8); end
        checks++; if (out_inst[1] !== prev + 32'd4 + OFS) begin errors++; $display("FAIL stream_out_inst1[%0d] got=%h exp=%h", n, out_inst[1], prev + 32'd4 + OFS); end
      end
      tick();
    end
    icache_hit = '0;
    tick();
    checks++; if (ibuf_count !== 4'd0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", ibuf_count); end
  endtask

  task automatic test_partial_hit();
    icache_hit = '1;
    do_redirect(32'h40);
    icache_hit = 3'b101; dispatch_take = 2'd0; drive_slots(32'h40);
    #1;
    checks++; if (fetch_pc !== 32'h40) begin errors++; $display("FAIL partial_pc0 got=%h exp=40", fetch_pc); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL partial_stall0 got=%b exp=0", fetch_stall); end
    tick();
    icache_hit = 3'b000;
    #1;
    checks++; if (fetch_pc !== 32'h44) begin errors++; $display("FAIL partial_pc1 got=%h exp=44", fetch_pc); end
    checks++; if (ibuf_count !== 4'd1) begin errors++; $display("FAIL partial_count1 got=%0d exp=1", ibuf_count); end
    checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL partial_valid got=%b exp=001", out_valid); end
    checks++; if (out_pc[0] !== 32'h40) begin errors++; $display("FAIL partial_out_pc got=%h exp=40", out_pc[0]); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL partial_miss_stall got=%b exp=1", fetch_stall); end
    tick();
    checks++; if (fetch_pc !== 32'h44) begin errors++; $display("FAIL partial_pc_hold got=%h exp=44", fetch_pc); end
    checks++; if (ibuf_count !== 4'd1) begin errors++; $display("FAIL partial_count_hold got=%0d exp=1", ibuf_count); end
    dispatch_take = 2'd3;
    tick();
    checks++; if (ibuf_count !== 4'd0) begin errors++; $display("FAIL partial_clamped_take got=%0d exp=0", ibuf_count); end
  endtask

  task automatic test_full_wrap();
    logic [3:0]  exp_cnt [5];
    logic [31:0] exp_pc  [5];
    logic        exp_stl [5];
    exp_cnt = '{4'd0, 4'd3, 4'd6, 4'd8, 4'd8};
    exp_pc  = '{32'h100, 32'h10C, 32'h118, 32'h120, 32'h120};
    exp_stl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    icache_hit = '1;
    do_redirect(32'h100);
    dispatch_take = 2'd0;
    for (int n = 0; n < 5; n++) begin
      drive_slots(exp_pc[n]);
      #1;
      checks++; if (ibuf_count !== exp_cnt[n]) begin errors++; $display("FAIL full_count[%0d] got=%0d exp=%0d", n, ibuf_count, exp_cnt[n]); end
      checks++; if (fetch_pc !== exp_pc[n]) begin errors++; $display("FAIL full_pc[%0d] got=%h exp=%h", n, fetch_pc, exp_pc[n]); end
      checks++; if (fetch_stall !== exp_stl[n]) begin errors++; $display("FAIL full_stall[%0d] got=%b exp=%b", n, fetch_stall, exp_stl[n]); end
      tick();
    end
    dispatch_take = 2'd3; drive_slots(32'h120);
    #1;
    checks++; if (out_pc[0] !== 32'h100 || out_pc[2] !== 32'h108) begin errors++; $display("FAIL full_window got=%h,%h exp=100,108", out_pc[0], out_pc[2]); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL full_take_stall got=%b exp=1", fetch_stall); end
    tick();
    checks++; if (ibuf_count !== 4'd5) begin errors++; $display("FAIL wrap_count0 got=%0d exp=5", ibuf_count); end
    checks++; if (out_pc[0] !== 32'h10C) begin errors++; $display("FAIL wrap_pc0 got=%h exp=10c", out_pc[0]); end
    checks++; if (fetch_pc !== 32'h120) begin errors++; $display("FAIL wrap_fetch0 got=%h exp=120", fetch_pc); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL wrap_stall got=%b exp=0", fetch_stall); end
    tick();
    drive_slots(32'h12C);
    #1;
    checks++; if (out_pc[0] !== 32'h118 || out_pc[2] !== 32'h120) begin errors++; $display("FAIL wrap_window1 got=%h,%h exp=118,120", out_pc[0], out_pc[2]); end
    checks++; if (out_inst[2] !== 32'h120 + OFS) begin errors++; $display("FAIL wrap_inst1 got=%h exp=%h", out_inst[2], 32'h120 + OFS); end
    checks++; if (ibuf_count !== 4'd5) begin errors++; $display("FAIL wrap_count1 got=%0d exp=5", ibuf_count); end
    tick();
    checks++; if (out_pc[0] !== 32'h124 || out_pc[2] !== 32'h12C) begin errors++; $display("FAIL wrap_window2 got=%h,%h exp=124,12c", out_pc[0], out_pc[2]); end
    checks++; if (out_valid !== 3'b111) begin errors++; $display("FAIL wrap_valid got=%b exp=111", out_valid); end
  endtask

  task automatic test_redirect_flush();
    drive_slots(32'h138);
    redirect_valid = 1'b1; redirect_pc = 32'h1003;
    #1;
    checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL redir_same_cycle_valid got=%b exp=000", out_valid); end
    checks++; if (ibuf_count !== 4'd5) begin errors++; $display("FAIL redir_pre_count got=%0d exp=5", ibuf_count); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (ibuf_count !== 4'd0) begin errors++; $display("FAIL redir_count got=%0d exp=0", ibuf_count); end
    checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("FAIL redir_pc got=%h exp=1000", fetch_pc); end
    checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL redir_valid got=%b exp=000", out_valid); end
  endtask

  task automatic test_wfi();
    do_redirect(32'h80);
    dispatch_take = 2'd0; icache_hit = '1;
    drive_slots(32'h80); icache_inst[1] = WFI;
    #1;
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL wfi_stall0 got=%b exp=0", fetch_stall); end
    tick();
    checks++; if (ibuf_count !== 4'd2) begin errors++; $display("FAIL wfi_count got=%0d exp=2", ibuf_count); end
    checks++; if (fetch_pc !== 32'h88) begin errors++; $display("FAIL wfi_pc got=%h exp=88", fetch_pc); end
    checks++; if (out_valid !== 3'b011) begin errors++; $display("FAIL wfi_valid got=%b exp=011", out_valid); end
    checks++; if (out_pc[0] !== 32'h80 || out_pc[1] !== 32'h84) begin errors++; $display("FAIL wfi_out_pc got=%h,%h exp=80,84", out_pc[0], out_pc[1]); end
    checks++; if (out_inst[1] !== WFI) begin errors++; $display("FAIL wfi_inst got=%h exp=%h", out_inst[1], WFI); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL wfi_halt_stall got=%b exp=0", fetch_stall); end
    dispatch_take = 2'd1;
    tick();
    checks++; if (ibuf_count !== 4'd1 || fetch_pc !== 32'h88) begin errors++; $display("FAIL wfi_drain1 got=%0d/%h exp=1/88", ibuf_count, fetch_pc); end
    checks++; if (out_pc[0] !== 32'h84) begin errors++; $display("FAIL wfi_drain_head got=%h exp=84", out_pc[0]); end
    tick();
    checks++; if (ibuf_count !== 4'd0 || fetch_pc !== 32'h88) begin errors++; $display("FAIL wfi_drain2 got=%0d/%h exp=0/88", ibuf_count, fetch_pc); end
    do_redirect(32'h200);
    checks++; if (fetch_pc !== 32'h200) begin errors++; $display("FAIL wfi_resume_pc got=%h exp=200", fetch_pc); end
    drive_slots(32'h200); dispatch_take = 2'd0;
    tick();
    checks++; if (ibuf_count !== 4'd3 || fetch_pc !== 32'h20C) begin errors++; $display("FAIL wfi_resume_fetch got=%0d/%h exp=3/20c", ibuf_count, fetch_pc); end
  endtask

  task automatic test_async_reset();
    drive_slots(32'h20C);
    tick();
    checks++; if (ibuf_count !== 4'd6) begin errors++; $display("FAIL areset_pre_count got=%0d exp=6", ibuf_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ibuf_count !== 4'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", ibuf_count); end
    checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL areset_valid got=%b exp=000", out_valid); end
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL areset_pc got=%h exp=0", fetch_pc); end
    checks++; if (out_inst !== '0 || out_pc !== '0) begin errors++; $display("FAIL areset_window got=%h/%h exp=0", out_inst, out_pc); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL areset_stall got=%b exp=0", fetch_stall); end
    tick();
    reset = 1'b0; drive_slots(32'h0);
    tick();
    checks++; if (ibuf_count !== 4'd3 || fetch_pc !== 32'hC) begin errors++; $display("FAIL areset_restart got=%0d/%h exp=3/c", ibuf_count, fetch_pc); end
    checks++; if (out_pc[1] !== 32'h4) begin errors++; $display("FAIL areset_restart_pc got=%h exp=4", out_pc[1]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_partial_hit();
    test_full_wrap();
    test_redirect_flush();
    test_wfi();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
